// File: rtl/fft_frame_sequencer.sv
// Circular sample buffer that emits the latest FRAME_LEN samples, oldest first,
// every HOP new samples once the downstream FFT reports the previous frame done.
module fft_frame_sequencer #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 256,
  parameter int HOP       = 128
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [WIDTH-1:0]             sample_in,
  input  logic                         sample_valid_in,
  input  logic                         enable_in,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(FRAME_LEN)-1:0] out_index,
  output logic                         out_valid,
  input  logic                         out_ready_in,
  output logic                         out_last,
  input  logic                         result_done_in,
  output logic                         busy_out,
  output logic [15:0]                  frame_count_out,
  output logic                         overrun_out
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C   = CW'(FRAME_LEN);
  localparam logic [CW-1:0] HOP_C    = CW'(HOP);
  localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {FILL, WAIT_HOP, STREAM, WAIT_RESULT} state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]     new_count_reg, new_count_next;
  logic [AW-1:0]     rd_base_reg, rd_base_next;
  logic [AW-1:0]     out_idx_reg, out_idx_next;
  logic              out_valid_reg, out_valid_next;
  logic [15:0]       frame_count_reg, frame_count_next;
  logic              overrun_reg, overrun_next;
  logic [CW-1:0]     w_cnt_reg, w_cnt_next;
  logic [CW-1:0]     r_cnt_reg, r_cnt_next;
  logic [CW-1:0]     cnt_inc;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [WIDTH-1:0]  mem [FRAME_LEN];
  logic [WIDTH-1:0]  rd_data_reg;

  // Buffer with read enable: the output beat is held simply by not re-reading.
  always_ff @(posedge clk_in) begin
    if (sample_valid_in) mem[wr_ptr_reg] <= sample_in;
    if (rd_en)           rd_data_reg     <= mem[rd_addr];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg       <= FILL;
      wr_ptr_reg      <= '0;
      new_count_reg   <= '0;
      rd_base_reg     <= '0;
      out_idx_reg     <= '0;
      out_valid_reg   <= 1'b0;
      frame_count_reg <= '0;
      overrun_reg     <= 1'b0;
      w_cnt_reg       <= '0;
      r_cnt_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      wr_ptr_reg      <= wr_ptr_next;
      new_count_reg   <= new_count_next;
      rd_base_reg     <= rd_base_next;
      out_idx_reg     <= out_idx_next;
      out_valid_reg   <= out_valid_next;
      frame_count_reg <= frame_count_next;
      overrun_reg     <= overrun_next;
      w_cnt_reg       <= w_cnt_next;
      r_cnt_reg       <= r_cnt_next;
    end
  end

  assign cnt_inc = (sample_valid_in && new_count_reg != FULL_C) ? new_count_reg + CW'(1)
                                                                : new_count_reg;

  always_comb begin
    state_next       = state_reg;
    wr_ptr_next      = wr_ptr_reg + AW'(sample_valid_in);
    new_count_next   = cnt_inc;
    rd_base_next     = rd_base_reg;
    out_idx_next     = out_idx_reg;
    out_valid_next   = out_valid_reg;
    frame_count_next = frame_count_reg;
    overrun_next     = overrun_reg;
    w_cnt_next       = w_cnt_reg;
    r_cnt_next       = r_cnt_reg;
    rd_en            = 1'b0;
    rd_addr          = rd_base_reg + out_idx_reg;

    case (state_reg)
      FILL: begin
        // First frame is eligible as soon as the buffer is full.
        if (cnt_inc == FULL_C) begin
          state_next     = WAIT_HOP;
          new_count_next = HOP_C;
        end
      end
      WAIT_HOP: begin
        if (new_count_reg >= HOP_C && enable_in) begin
          state_next     = STREAM;
          rd_base_next   = wr_ptr_next;
          new_count_next = CW'(sample_valid_in);
          out_idx_next   = '0;
          w_cnt_next     = '0;
          r_cnt_next     = '0;
        end
      end
      STREAM: begin
        if (sample_valid_in) begin
          if (w_cnt_reg >= r_cnt_reg) overrun_next = 1'b1;
          if (w_cnt_reg != FULL_C)    w_cnt_next   = w_cnt_reg + CW'(1);
        end
        if (!out_valid_reg) begin
          rd_en          = 1'b1;
          out_valid_next = 1'b1;
        end else if (out_ready_in) begin
          r_cnt_next = r_cnt_reg + CW'(1);
          if (out_idx_reg == LAST_IDX) begin
            out_valid_next   = 1'b0;
            out_idx_next     = '0;
            frame_count_next = frame_count_reg + 16'd1;
            state_next       = WAIT_RESULT;
          end else begin
            // Fetch the next beat now so the register is ready for the next edge.
            out_idx_next = out_idx_reg + AW'(1);
            rd_en        = 1'b1;
            rd_addr      = rd_base_reg + out_idx_reg + AW'(1);
          end
        end
      end
      WAIT_RESULT: begin
        if (result_done_in) state_next = WAIT_HOP;
      end
      default: state_next = FILL;
    endcase
  end

  assign out_data        = out_valid_reg ? rd_data_reg : '0;
  assign out_index       = out_idx_reg;
  assign out_valid       = out_valid_reg;
  assign out_last        = out_valid_reg && (out_idx_reg == LAST_IDX);
  assign busy_out        = (state_reg == STREAM) || (state_reg == WAIT_RESULT);
  assign frame_count_out = frame_count_reg;
  assign overrun_out     = overrun_reg;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer with FRAME_LEN=8, HOP=4, WIDTH=8.
module tb_fft_frame_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] sample_in = '0;
  logic       sample_valid_in = 1'b0;
  logic       enable_in = 1'b1;
  logic [7:0] out_data;
  logic [2:0] out_index;
  logic       out_valid;
  logic       out_ready_in = 1'b1;
  logic       out_last;
  logic       result_done_in = 1'b0;
  logic       busy_out;
  logic [15:0] frame_count_out;
  logic       overrun_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  fft_frame_sequencer #(.WIDTH(8), .FRAME_LEN(8), .HOP(4)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_in       (sample_in),
    .sample_valid_in (sample_valid_in),
    .enable_in       (enable_in),
    .out_data        (out_data),
    .out_index       (out_index),
    .out_valid       (out_valid),
    .out_ready_in    (out_ready_in),
    .out_last        (out_last),
    .result_done_in  (result_done_in),
    .busy_out        (busy_out),
    .frame_count_out (frame_count_out),
    .overrun_out     (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic write(input logic [7:0] v);
    sample_in       = v;
    sample_valid_in = 1'b1;
    tick();
    sample_valid_in = 1'b0;
  endtask

  task automatic pulse_done();
    result_done_in = 1'b1;
    tick();
    result_done_in = 1'b0;
  endtask

  // Frames in this bench always hold consecutive sample values.
  task automatic push_frame(input int first);
    for (int k = 0; k < 8; k++) begin
      beat_t b;
      b.data = 8'(first + k);
      b.idx  = 3'(k);
      b.last = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_count(input int exp, input int budget);
    int n = 0;
    while (frame_count_out != 16'(exp) && n < budget) begin
      tick();
      n++;
    end
    check("frame_count", 32'(frame_count_out), 32'(exp));
  endtask

  task automatic monitor_loop();
    logic       stall_prev = 1'b0;
    logic [7:0] d_prev = '0;
    logic [2:0] i_prev = '0;
    logic       l_prev = 1'b0;
    forever begin
      @(negedge clk_in);
      if (stall_prev && !rst_in) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data",  32'(out_data),  32'(d_prev));
        check("hold_index", 32'(out_index), 32'(i_prev));
        check("hold_last",  32'(out_last),  32'(l_prev));
      end
      if (out_valid && out_ready_in && !rst_in) begin
        $display("beat index=%0d data=%0d last=%0d", out_index, out_data, out_last);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0d index %0d, required no beat", out_data, out_index);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data",  32'(out_data),  32'(e.data));
          check("beat_index", 32'(out_index), 32'(e.idx));
          check("beat_last",  32'(out_last),  32'(e.last));
        end
      end
      stall_prev = out_valid && !out_ready_in && !rst_in;
      d_prev = out_data;
      i_prev = out_index;
      l_prev = out_last;
    end
  endtask

  initial begin
    int n;
    fork
      monitor_loop();
    join_none

    #2;
    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_last",    32'(out_last),  32'd0);
    check("rst_index",   32'(out_index), 32'd0);
    check("rst_data",    32'(out_data),  32'd0);
    check("rst_busy",    32'(busy_out),  32'd0);
    check("rst_count",   32'(frame_count_out), 32'd0);
    check("rst_overrun", 32'(overrun_out), 32'd0);
    #20 rst_in = 1'b0;
    tick();

    // 1: first frame after eight sparse writes
    for (int v = 1; v <= 7; v++) begin
      write(8'(v));
      idle(2);
    end
    check("fill_no_busy", 32'(busy_out), 32'd0);
    push_frame(1);
    write(8'd8);
    n = 0;
    while (!out_valid && n < 3) begin
      tick();
      n++;
    end
    check("first_latency_valid", 32'(out_valid), 32'd1);
    check("first_busy", 32'(busy_out), 32'd1);
    wait_count(1, 20);
    check("wait_result_busy", 32'(busy_out), 32'd1);

    // 2: hop; three new samples are not enough
    pulse_done();
    write(8'd9); write(8'd10); write(8'd11);
    idle(6);
    check("hop_short_busy", 32'(busy_out), 32'd0);
    push_frame(5);
    write(8'd12);
    wait_count(2, 20);

    // 3: backpressure with ready pattern 1,0,0
    pulse_done();
    push_frame(9);
    for (int v = 13; v <= 16; v++) write(8'(v));
    n = 0;
    while (frame_count_out != 16'd3 && n < 60) begin
      out_ready_in = (n % 3 == 0);
      tick();
      n++;
    end
    out_ready_in = 1'b1;
    check("bp_frame_count", 32'(frame_count_out), 32'd3);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: no frame without result_done, then only the latest window
    for (int v = 17; v <= 32; v++) write(8'(v));
    idle(3);
    check("gate_count", 32'(frame_count_out), 32'd3);
    push_frame(25);
    pulse_done();
    wait_count(4, 20);
    pulse_done();
    idle(10);
    check("gate_no_second", 32'(frame_count_out), 32'd4);
    check("gate_idle_busy", 32'(busy_out), 32'd0);
    check("pre_overrun", 32'(overrun_out), 32'd0);

    // 5: overrun while stalled
    push_frame(29);
    write(8'd33); write(8'd34); write(8'd35);
    out_ready_in = 1'b0;
    write(8'd36);
    idle(2);
    write(8'd37);
    check("overrun_set", 32'(overrun_out), 32'd1);
    out_ready_in = 1'b1;
    wait_count(5, 20);
    check("overrun_sticky", 32'(overrun_out), 32'd1);

    // 6: asynchronous reset mid-stream
    pulse_done();
    out_ready_in = 1'b0;
    write(8'd38); write(8'd39); write(8'd40);
    n = 0;
    while (!out_valid && n < 5) begin
      tick();
      n++;
    end
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #3 rst_in = 1'b1;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_busy",  32'(busy_out),  32'd0);
    idle(2);
    #3 rst_in = 1'b0;
    out_ready_in = 1'b1;
    tick();
    check("post_reset_count",   32'(frame_count_out), 32'd0);
    check("post_reset_overrun", 32'(overrun_out), 32'd0);
    for (int v = 41; v <= 47; v++) begin
      write(8'(v));
      idle(1);
    end
    idle(3);
    check("refill_busy", 32'(busy_out), 32'd0);
    push_frame(41);
    write(8'd48);
    wait_count(1, 20);
    idle(2);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
